single_port_blockram_controller: RTL and testbench



---
 rtl/single_port_blockram_controller_pkg.sv | 15 +
 rtl/blockram_response_fifo.sv | 64 ++++++
 rtl/single_port_blockram_controller.sv | 117 +++++++++++
 tb/tb_single_port_blockram_controller.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/single_port_blockram_controller_pkg.sv
// Shared types and constants for the single-port block RAM front end.
package single_port_blockram_controller_pkg;

    localparam int BYTE_LEN_IN_BITS = 8;

    typedef enum logic {
        STATE_INIT,
        STATE_RUN
    } ctrl_state_t;

    function automatic int fifo_count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/blockram_response_fifo.sv
// Synchronous FIFO holding read data until the consumer takes it.
module blockram_response_fifo
    import single_port_blockram_controller_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int CNT_W = fifo_count_width(DEPTH),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             push_in,
    input  logic [WIDTH-1:0] push_data_in,
    input  logic             pop_in,
    output logic [WIDTH-1:0] pop_data_out,
    output logic             full_out,
    output logic             empty_out,
    output logic [CNT_W-1:0] count_out
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full_out     = (count == CNT_W'(DEPTH));
    assign empty_out    = (count == '0);
    assign count_out    = count;
    assign pop_data_out = storage[rd_ptr];
    assign do_push      = push_in && !full_out;
    assign do_pop       = pop_in && !empty_out;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data_in;
        end
    end

endmodule

// File: rtl/single_port_blockram_controller.sv
// Owns one single-port block RAM: clears it after reset, then serves a
// valid/ready request stream with buffered read responses.
module single_port_blockram_controller
    import single_port_blockram_controller_pkg::*;
#(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET = 64,
    parameter int SET_PTR_WIDTH_IN_BITS = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS,
    parameter int RESP_FIFO_DEPTH = 4
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    output logic                                 init_done_out,
    input  logic                                 request_valid_in,
    output logic                                 request_ready_out,
    input  logic [WRITE_MASK_LEN-1:0]            request_write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     request_set_addr_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_write_entry_in,
    output logic                                 response_valid_out,
    input  logic                                 response_ready_in,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] response_read_entry_out,
    output logic                                 access_en_out,
    output logic [WRITE_MASK_LEN-1:0]            write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]     access_set_addr_out,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_out,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_in
);

    localparam int CNT_W = fifo_count_width(RESP_FIFO_DEPTH);
    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET =
        SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1);
    localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W + 1)'(RESP_FIFO_DEPTH);

    ctrl_state_t                      state_q;
    ctrl_state_t                      state_d;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] init_addr_q;
    logic                             read_inflight_q;
    logic [CNT_W-1:0]                 fifo_count;
    logic                             fifo_full;
    logic                             fifo_empty;
    logic [CNT_W:0]                   occupancy;
    logic                             handshake;
    logic                             read_req;
    logic                             running;

    assign running   = !reset_in && (state_q == STATE_RUN);
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(read_inflight_q);

    // An accepted read reserves its FIFO slot immediately, so the push a
    // cycle later can never meet a full FIFO.
    assign request_ready_out = running && !fifo_full && (occupancy < DEPTH_LIMIT);
    assign handshake         = request_valid_in && request_ready_out;
    assign read_req          = handshake && (request_write_en_in == '0);
    assign init_done_out     = running;

    always_comb begin
        state_d             = state_q;
        access_en_out       = 1'b0;
        write_en_out        = '0;
        access_set_addr_out = '0;
        write_entry_out     = '0;
        if (!reset_in) begin
            unique case (state_q)
                STATE_INIT: begin
                    access_en_out       = 1'b1;
                    write_en_out        = '1;
                    access_set_addr_out = init_addr_q;
                    if (init_addr_q == LAST_SET) begin
                        state_d = STATE_RUN;
                    end
                end
                STATE_RUN: begin
                    if (handshake) begin
                        access_en_out       = 1'b1;
                        write_en_out        = request_write_en_in;
                        access_set_addr_out = request_set_addr_in;
                        write_entry_out     = request_write_entry_in;
                    end
                end
                default: state_d = STATE_INIT;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q         <= STATE_INIT;
            init_addr_q     <= '0;
            read_inflight_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            read_inflight_q <= read_req;
            if (state_q == STATE_INIT) begin
                init_addr_q <= init_addr_q + 1'b1;
            end
        end
    end

    blockram_response_fifo #(
        .WIDTH (SINGLE_ENTRY_SIZE_IN_BITS),
        .DEPTH (RESP_FIFO_DEPTH)
    ) u_resp_fifo (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .push_in      (read_inflight_q),
        .push_data_in (read_entry_in),
        .pop_in       (response_valid_out && response_ready_in),
        .pop_data_out (response_read_entry_out),
        .full_out     (fifo_full),
        .empty_out    (fifo_empty),
        .count_out    (fifo_count)
    );

    assign response_valid_out = !reset_in && !fifo_empty;

endmodule

// File: tb/tb_single_port_blockram_controller.sv
// Directed bench for the block RAM controller with a read-first RAM model.
module tb_single_port_blockram_controller;

    localparam int W  = 64;
    localparam int N  = 64;
    localparam int AW = 6;
    localparam int M  = 8;

    logic          clk = 1'b0;
    logic          reset_in;
    logic          init_done_out;
    logic          request_valid_in;
    logic          request_ready_out;
    logic [M-1:0]  request_write_en_in;
    logic [AW-1:0] request_set_addr_in;
    logic [W-1:0]  request_write_entry_in;
    logic          response_valid_out;
    logic          response_ready_in;
    logic [W-1:0]  response_read_entry_out;
    logic          access_en_out;
    logic [M-1:0]  write_en_out;
    logic [AW-1:0] access_set_addr_out;
    logic [W-1:0]  write_entry_out;
    logic [W-1:0]  read_entry_in = '0;

    int n_checks = 0;
    int n_fails  = 0;
    logic [W-1:0] exp_q [$];

    always #5 clk = ~clk;

    single_port_blockram_controller dut (
        .clk_in                  (clk),
        .reset_in                (reset_in),
        .init_done_out           (init_done_out),
        .request_valid_in        (request_valid_in),
        .request_ready_out       (request_ready_out),
        .request_write_en_in     (request_write_en_in),
        .request_set_addr_in     (request_set_addr_in),
        .request_write_entry_in  (request_write_entry_in),
        .response_valid_out      (response_valid_out),
        .response_ready_in       (response_ready_in),
        .response_read_entry_out (response_read_entry_out),
        .access_en_out           (access_en_out),
        .write_en_out            (write_en_out),
        .access_set_addr_out     (access_set_addr_out),
        .write_entry_out         (write_entry_out),
        .read_entry_in           (read_entry_in)
    );

    // Read-first RAM, seeded with garbage so the clear sweep is observable.
    logic [W-1:0] mem [N];
    logic         mem_seeded = 1'b0;

    always @(posedge clk) begin
        if (!mem_seeded) begin
            for (int i = 0; i < N; i++) mem[i] <= 64'hBAD0_0000_0000_0000 | 64'(i);
            mem_seeded <= 1'b1;
        end else if (access_en_out) begin
            read_entry_in <= mem[access_set_addr_out];
            for (int b = 0; b < M; b++) begin
                if (write_en_out[b])
                    mem[access_set_addr_out][b*8 +: 8] <= write_entry_out[b*8 +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (response_valid_out && response_ready_in) begin
            if (exp_q.size() == 0) check("unexpected_resp", 1, 0);
            else check("resp_data", response_read_entry_out, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        request_valid_in       = 1'b0;
        request_write_en_in    = '0;
        request_set_addr_in    = '0;
        request_write_entry_in = '0;
    endtask

    task automatic issue(input logic [M-1:0] mask, input logic [AW-1:0] addr,
                         input logic [W-1:0] data, input string tag);
        request_valid_in       = 1'b1;
        request_write_en_in    = mask;
        request_set_addr_in    = addr;
        request_write_entry_in = data;
        @(negedge clk);
        check({tag, "_ready"}, 64'(request_ready_out), 1);
        check({tag, "_ram_en"}, 64'(access_en_out), 1);
        check({tag, "_ram_mask"}, 64'(write_en_out), 64'(mask));
        check({tag, "_ram_addr"}, 64'(access_set_addr_out), 64'(addr));
        step();
        idle();
    endtask

    task automatic wr(input logic [M-1:0] mask, input logic [AW-1:0] addr,
                      input logic [W-1:0] data, input string tag);
        issue(mask, addr, data, tag);
    endtask

    task automatic rd(input logic [AW-1:0] addr, input logic [W-1:0] want,
                      input string tag);
        exp_q.push_back(want);
        issue('0, addr, '0, tag);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        check({tag, "_drain"}, 64'(exp_q.size()), 0);
    endtask

    task automatic reset_and_init(input string tag);
        reset_in = 1'b1;
        @(negedge clk);
        check({tag, "_rst_en"}, 64'(access_en_out), 0);
        check({tag, "_rst_mask"}, 64'(write_en_out), 0);
        check({tag, "_rst_ready"}, 64'(request_ready_out), 0);
        check({tag, "_rst_done"}, 64'(init_done_out), 0);
        step();
        reset_in = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check({tag, "_init_en"}, 64'(access_en_out), 1);
            check({tag, "_init_addr"}, 64'(access_set_addr_out), 64'(i));
            check({tag, "_init_mask"}, 64'(write_en_out), 64'hFF);
            check({tag, "_init_data"}, write_entry_out, 0);
            check({tag, "_init_ready"}, 64'(request_ready_out), 0);
            check({tag, "_init_done"}, 64'(init_done_out), 0);
            check({tag, "_init_valid"}, 64'(response_valid_out), 0);
            step();
        end
        @(negedge clk);
        check({tag, "_done"}, 64'(init_done_out), 1);
        check({tag, "_run_ready"}, 64'(request_ready_out), 1);
        check({tag, "_run_en"}, 64'(access_en_out), 0);
        step();
    endtask

    int idx;
    int acc;

    initial begin
        reset_in          = 1'b1;
        response_ready_in = 1'b1;
        idle();
        step();
        step();
        reset_and_init("boot");

        rd(6'd0, 64'h0, "rd0");
        rd(6'd31, 64'h0, "rd31");
        rd(6'd63, 64'h0, "rd63");
        wait_drain("zero");

        // Write then read the same set on the next cycle; check latency.
        wr(8'hFF, 6'd5, 64'h1122334455667788, "wr5");
        exp_q.push_back(64'h1122334455667788);
        issue('0, 6'd5, '0, "rd5");
        @(negedge clk);
        check("lat_t1_valid", 64'(response_valid_out), 0);
        step();
        @(negedge clk);
        check("lat_t2_valid", 64'(response_valid_out), 1);
        check("lat_t2_data", response_read_entry_out, 64'h1122334455667788);
        step();
        wait_drain("lat");

        wr(8'h0F, 6'd5, 64'hAAAAAAAAAAAAAAAA, "pwr5");
        rd(6'd5, 64'h11223344AAAAAAAA, "prd5");
        wait_drain("partial");

        for (int i = 0; i < 16; i++) begin
            wr(8'hFF, AW'(i), 64'hC0DE_0000_0000_0000 + 64'(i), "fill");
        end

        // Backpressure: only four reads fit with the consumer stalled.
        response_ready_in = 1'b0;
        idx = 1;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            request_valid_in    = 1'b1;
            request_write_en_in = '0;
            request_set_addr_in = AW'(idx);
            @(negedge clk);
            if (request_ready_out) begin
                exp_q.push_back(64'hC0DE_0000_0000_0000 + 64'(idx));
                idx++;
                acc++;
            end
            step();
        end
        check("bp_accepted", 64'(acc), 4);
        @(negedge clk);
        check("bp_ready_low", 64'(request_ready_out), 0);
        check("bp_valid", 64'(response_valid_out), 1);
        check("bp_head", response_read_entry_out, 64'hC0DE_0000_0000_0001);
        response_ready_in = 1'b1;
        step();
        for (int c = 0; c < 20 && idx <= 6; c++) begin
            request_valid_in    = 1'b1;
            request_write_en_in = '0;
            request_set_addr_in = AW'(idx);
            @(negedge clk);
            if (request_ready_out) begin
                exp_q.push_back(64'hC0DE_0000_0000_0000 + 64'(idx));
                idx++;
            end
            step();
        end
        idle();
        check("bp_total", 64'(idx), 7);
        wait_drain("bp");

        for (int i = 0; i < 16; i++) begin
            rd(AW'(i), 64'hC0DE_0000_0000_0000 + 64'(i), "b2b");
        end
        wait_drain("b2b");

        // Reset with three responses pending.
        response_ready_in = 1'b0;
        issue('0, 6'd0, '0, "pend0");
        issue('0, 6'd1, '0, "pend1");
        issue('0, 6'd2, '0, "pend2");
        step();
        @(negedge clk);
        check("pend_valid", 64'(response_valid_out), 1);
        step();
        reset_and_init("mid");
        exp_q.delete();
        response_ready_in = 1'b1;
        rd(6'd5, 64'h0, "post5");
        rd(6'd7, 64'h0, "post7");
        wait_drain("post");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
